clock_rate_monitor: RTL

- Receiving end of a divided clock such as `outclk` from the divider.
- Samples a slow clock-like signal in the fast `inclk` domain through a two-flop synchronizer.
- Emits single-cycle rise and fall ticks, measures the rise-to-rise period in `inclk` cycles, and reports lock against an expected frequency.
- Flags loss of the slow signal with a timeout; game-tick logic consumes ticks from this block instead of clocking on `outclk` directly.

---
 rtl/clock_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 46 ++++
 rtl/clock_rate_monitor.sv | 115 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and sizing helpers for the slow-clock rate monitor and its tick consumers.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEASURING = 2'd1,
    LOCKED    = 2'd2,
    LOST      = 2'd3
  } monitor_state_t;

  // Width needed to hold a period count up to twice the nominal period.
  function automatic int period_width(input int in_freq, input int exp_freq);
    return $clog2(2 * (in_freq / exp_freq) + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, with priming and registered edge pulses.
module sync_edge_detect (
  input  logic inclk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_evt,
  output logic rise,
  output logic fall
);

  logic       s0_q, s1_q, s2_q, s2_d;
  logic [1:0] primed_q, primed_d;
  logic       rise_q, rise_d, fall_q, fall_d;

  // Until the chain has filled, s2 mirrors the incoming sample so a level that is
  // already high at reset release never looks like an edge.
  always_comb begin
    primed_d = {primed_q[0], 1'b1};
    s2_d     = primed_q[1] ? s1_q : s0_q;
    rise_evt = primed_q[1] & s1_q & ~s2_q;
    rise_d   = rise_evt;
    fall_d   = primed_q[1] & ~s1_q & s2_q;
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      primed_q <= 2'b00;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s0_q     <= async_in;
      s1_q     <= s0_q;
      s2_q     <= s2_d;
      primed_q <= primed_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clock_rate_monitor.sv
// Measures the rise-to-rise period of a slow asynchronous clock-like signal and reports
// frequency lock and signal loss; downstream logic consumes rise/fall ticks from here.
module clock_rate_monitor
  import clock_pkg::*;
#(
  parameter  int IN_FREQUENCY       = 10**7,
  parameter  int EXPECTED_FREQUENCY = 100,
  parameter  int TOL_SHIFT          = 4,
  parameter  int LOCK_COUNT         = 2,
  localparam int EXP_PERIOD         = IN_FREQUENCY / EXPECTED_FREQUENCY,
  localparam int TOL                = EXP_PERIOD >> TOL_SHIFT,
  localparam int TIMEOUT_COUNT      = 2 * EXP_PERIOD,
  localparam int PW                 = period_width(IN_FREQUENCY, EXPECTED_FREQUENCY)
) (
  input  logic          inclk,
  input  logic          rst_n,
  input  logic          slowclk,
  output logic          rise_tick,
  output logic          fall_tick,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          timeout
);

  localparam int LW = $clog2(LOCK_COUNT + 1);

  localparam logic [PW:0]   EXP_W = (PW+1)'(EXP_PERIOD);
  localparam logic [PW:0]   TOL_W = (PW+1)'(TOL);
  localparam logic [PW:0]   TO_W  = (PW+1)'(TIMEOUT_COUNT);
  localparam logic [PW-1:0] TO_P  = PW'(TIMEOUT_COUNT);
  localparam logic [PW-1:0] TO_M1 = PW'(TIMEOUT_COUNT - 1);
  localparam logic [LW-1:0] LC    = LW'(LOCK_COUNT);

  logic rise_evt, rise, fall;

  sync_edge_detect u_sync (
    .inclk    (inclk),
    .rst_n    (rst_n),
    .async_in (slowclk),
    .rise_evt (rise_evt),
    .rise     (rise),
    .fall     (fall)
  );

  monitor_state_t state_q, state_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  period_q, period_d;
  logic           pv_q, pv_d;
  logic [LW-1:0]  lock_cnt_q, lock_cnt_d, lock_next;
  logic [PW:0]    meas_w, diff_w;
  logic           in_tol;

  always_comb begin
    // Counter is one behind the cycle count between rise events, so +1 gives the period.
    meas_w = {1'b0, cnt_q} + (PW+1)'(1);
    if (meas_w > TO_W) meas_w = TO_W;
    diff_w = (meas_w >= EXP_W) ? meas_w - EXP_W : EXP_W - meas_w;
    in_tol = (diff_w <= TOL_W);

    lock_next = (lock_cnt_q == LC) ? LC : lock_cnt_q + LW'(1);

    if (rise_evt)            cnt_d = '0;
    else if (cnt_q != TO_P)  cnt_d = cnt_q + PW'(1);
    else                     cnt_d = cnt_q;

    state_d    = state_q;
    period_d   = period_q;
    pv_d       = 1'b0;
    lock_cnt_d = lock_cnt_q;

    case (state_q)
      IDLE, LOST: begin
        if (rise_evt) state_d = MEASURING;
      end
      MEASURING, LOCKED: begin
        // A rise in the same cycle the counter would saturate wins over the timeout.
        if (rise_evt) begin
          period_d   = meas_w[PW-1:0];
          pv_d       = 1'b1;
          lock_cnt_d = in_tol ? lock_next : '0;
          state_d    = (lock_cnt_d == LC) ? LOCKED : MEASURING;
        end else if (cnt_q >= TO_M1) begin
          state_d    = LOST;
          lock_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign rise_tick    = rise;
  assign fall_tick    = fall;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = (state_q == LOCKED);
  assign timeout      = (state_q == LOST);

endmodule
